// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer computing Q = k*P on
// Ed25519 by driving a single PointAdd instance. P and Q are kept in the
// PointAdd output representation (extended coordinates).
// Optional build macro: SCALAR_CONST_TIME_EN -- fixed schedule of one double and
// one add for every scalar bit, independent of k.
module scalar_mult_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [254:0] i_scalar,
    input  logic [254:0] i_x,
    input  logic [254:0] i_y,
    output logic         o_busy,
    output logic         o_done,
    output logic [254:0] o_x,
    output logic [254:0] o_y,
    output logic [254:0] o_z,
    output logic [254:0] o_t,
    output logic         o_pa_start,
    output logic         o_pa_doubling,
    output logic         o_pa_initial,
    output logic [254:0] o_pa_x1,
    output logic [254:0] o_pa_y1,
    output logic [254:0] o_pa_z1,
    output logic [254:0] o_pa_t1,
    output logic [254:0] o_pa_x2,
    output logic [254:0] o_pa_y2,
    output logic [254:0] o_pa_z2,
    output logic [254:0] o_pa_t2,
    input  logic [254:0] i_pa_x3,
    input  logic [254:0] i_pa_y3,
    input  logic [254:0] i_pa_z3,
    input  logic [254:0] i_pa_t3,
    input  logic         i_pa_finished
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_P, S_WAIT_P, S_INIT_Q, S_WAIT_Q, S_SCAN,
        S_DBL, S_WAIT_DBL, S_ADD, S_WAIT_ADD, S_DONE
    } state_t;

    state_t       state;
    logic [254:0] k;
    logic [254:0] bx, by;
    logic [254:0] p_x, p_y, p_z, p_t;
    logic [254:0] q_x, q_y, q_z, q_t;
    logic [7:0]   idx;
    logic         q_is_id;

    logic bit_set;
    logic last_bit;

    assign bit_set  = k[idx];
    assign last_bit = (idx == 8'd0);

    // Q is only rewritten after the next accepted start (at the identity
    // conversion), so it can serve directly as the result bus.
    assign o_x = q_x;
    assign o_y = q_y;
    assign o_z = q_z;
    assign o_t = q_t;

    // Sequencer: state, operand registers and all PointAdd controls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            k             <= '0;
            bx            <= '0;
            by            <= '0;
            p_x           <= '0;
            p_y           <= '0;
            p_z           <= '0;
            p_t           <= '0;
            q_x           <= '0;
            q_y           <= '0;
            q_z           <= '0;
            q_t           <= '0;
            idx           <= '0;
            q_is_id       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_pa_start    <= 1'b0;
            o_pa_doubling <= 1'b0;
            o_pa_initial  <= 1'b0;
            o_pa_x1       <= '0;
            o_pa_y1       <= '0;
            o_pa_z1       <= '0;
            o_pa_t1       <= '0;
            o_pa_x2       <= '0;
            o_pa_y2       <= '0;
            o_pa_z2       <= '0;
            o_pa_t2       <= '0;
        end else begin
            o_pa_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        k       <= i_scalar;
                        bx      <= i_x;
                        by      <= i_y;
                        idx     <= 8'd254;
                        q_is_id <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= S_INIT_P;
                    end
                end
                S_INIT_P: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b1;
                    o_pa_doubling <= 1'b0;
                    o_pa_x1       <= bx;
                    o_pa_y1       <= by;
                    o_pa_z1       <= '0;
                    o_pa_t1       <= '0;
                    o_pa_x2       <= '0;
                    o_pa_y2       <= '0;
                    o_pa_z2       <= '0;
                    o_pa_t2       <= '0;
                    state         <= S_WAIT_P;
                end
                S_WAIT_P: begin
                    if (i_pa_finished) begin
                        p_x   <= i_pa_x3;
                        p_y   <= i_pa_y3;
                        p_z   <= i_pa_z3;
                        p_t   <= i_pa_t3;
                        state <= S_INIT_Q;
                    end
                end
                S_INIT_Q: begin
                    // Affine identity (0, 1) converted the same way as the base.
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b1;
                    o_pa_doubling <= 1'b0;
                    o_pa_x1       <= '0;
                    o_pa_y1       <= 255'd1;
                    o_pa_z1       <= '0;
                    o_pa_t1       <= '0;
                    o_pa_x2       <= '0;
                    o_pa_y2       <= '0;
                    o_pa_z2       <= '0;
                    o_pa_t2       <= '0;
                    state         <= S_WAIT_Q;
                end
                S_WAIT_Q: begin
                    if (i_pa_finished) begin
                        q_x   <= i_pa_x3;
                        q_y   <= i_pa_y3;
                        q_z   <= i_pa_z3;
                        q_t   <= i_pa_t3;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
`ifdef SCALAR_CONST_TIME_EN
                    state <= S_DBL;
`else
                    // Leading zeros cost one cycle each; the first set bit
                    // just copies P into Q instead of doubling the identity.
                    if (q_is_id) begin
                        if (bit_set) begin
                            q_x     <= p_x;
                            q_y     <= p_y;
                            q_z     <= p_z;
                            q_t     <= p_t;
                            q_is_id <= 1'b0;
                        end
                        if (last_bit) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx <= idx - 8'd1;
                        end
                    end else begin
                        state <= S_DBL;
                    end
`endif
                end
                S_DBL: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b0;
                    o_pa_doubling <= 1'b1;
                    o_pa_x1       <= q_x;
                    o_pa_y1       <= q_y;
                    o_pa_z1       <= q_z;
                    o_pa_t1       <= q_t;
                    o_pa_x2       <= q_x;
                    o_pa_y2       <= q_y;
                    o_pa_z2       <= q_z;
                    o_pa_t2       <= q_t;
                    state         <= S_WAIT_DBL;
                end
                S_WAIT_DBL: begin
                    if (i_pa_finished) begin
                        q_x <= i_pa_x3;
                        q_y <= i_pa_y3;
                        q_z <= i_pa_z3;
                        q_t <= i_pa_t3;
`ifdef SCALAR_CONST_TIME_EN
                        state <= S_ADD;
`else
                        if (bit_set) begin
                            state <= S_ADD;
                        end else if (last_bit) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx - 8'd1;
                            state <= S_SCAN;
                        end
`endif
                    end
                end
                S_ADD: begin
                    o_pa_start    <= 1'b1;
                    o_pa_initial  <= 1'b0;
                    o_pa_doubling <= 1'b0;
                    o_pa_x1       <= q_x;
                    o_pa_y1       <= q_y;
                    o_pa_z1       <= q_z;
                    o_pa_t1       <= q_t;
                    o_pa_x2       <= p_x;
                    o_pa_y2       <= p_y;
                    o_pa_z2       <= p_z;
                    o_pa_t2       <= p_t;
                    state         <= S_WAIT_ADD;
                end
                S_WAIT_ADD: begin
                    if (i_pa_finished) begin
`ifdef SCALAR_CONST_TIME_EN
                        // Dummy add on zero bits: result discarded.
                        if (bit_set) begin
`else
                        begin
`endif
                            q_x <= i_pa_x3;
                            q_y <= i_pa_y3;
                            q_z <= i_pa_z3;
                            q_t <= i_pa_t3;
                        end
                        if (last_bit) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx - 8'd1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// tb_scalar_mult_ctrl: randomized bench for scalar_mult_ctrl. PointAdd is
// replaced by a toy group model: a point with group value a is encoded as
// {a, a^MASK, a+1, 3a} (mod 2^255), conversion maps (x, y) to x ^ (y-1), so the
// identity (0, 1) maps to 0, and k*P is simply k*b mod 2^255.
// Honours SCALAR_CONST_TIME_EN for the expected operation schedule.
module tb_scalar_mult_ctrl;

    typedef struct packed {
        logic [254:0] x;
        logic [254:0] y;
        logic [254:0] z;
        logic [254:0] t;
    } pt_t;

    localparam logic [254:0] MASK = {{63{4'ha}}, 3'b101};
    localparam int LIM = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [254:0] scalar = '0, x = '0, y = '0;
    logic         busy, done;
    logic [254:0] ox, oy, oz, ot;
    logic         pa_start, pa_dbl, pa_init;
    logic [254:0] pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2;
    logic         pa_fin = 1'b0;
    pt_t          pa_res = '0;

    int n_tests = 0;
    int n_fail  = 0;

    scalar_mult_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_scalar(scalar),
        .i_x(x), .i_y(y), .o_busy(busy), .o_done(done),
        .o_x(ox), .o_y(oy), .o_z(oz), .o_t(ot),
        .o_pa_start(pa_start), .o_pa_doubling(pa_dbl), .o_pa_initial(pa_init),
        .o_pa_x1(pa_x1), .o_pa_y1(pa_y1), .o_pa_z1(pa_z1), .o_pa_t1(pa_t1),
        .o_pa_x2(pa_x2), .o_pa_y2(pa_y2), .o_pa_z2(pa_z2), .o_pa_t2(pa_t2),
        .i_pa_x3(pa_res.x), .i_pa_y3(pa_res.y), .i_pa_z3(pa_res.z),
        .i_pa_t3(pa_res.t), .i_pa_finished(pa_fin)
    );

    always #5 clk = ~clk;

    pt_t s1_cur, s2_cur, res_now;
    assign s1_cur  = {pa_x1, pa_y1, pa_z1, pa_t1};
    assign s2_cur  = {pa_x2, pa_y2, pa_z2, pa_t2};
    assign res_now = {ox, oy, oz, ot};

    function automatic pt_t enc(input logic [254:0] a);
        pt_t p;
        p.x = a;
        p.y = a ^ MASK;
        p.z = a + 255'd1;
        p.t = a * 255'd3;
        return p;
    endfunction

    function automatic bit valid_pt(input pt_t p);
        return p == enc(p.x);
    endfunction

    function automatic logic [254:0] base_val(input logic [254:0] bx, input logic [254:0] by);
        return bx ^ (by - 255'd1);
    endfunction

    function automatic bit op_ok(input logic ini, input logic dbl, input pt_t a, input pt_t b);
        if (ini && dbl) return 1'b0;
        if (ini) return (a.z == '0) && (a.t == '0) && (b == '0);
        if (dbl) return valid_pt(a) && (b == a);
        return valid_pt(a) && valid_pt(b);
    endfunction

    function automatic pt_t pa_eval(input logic ini, input logic dbl, input pt_t a, input pt_t b);
        if (ini) return enc(base_val(a.x, a.y));
        if (dbl) return enc(a.x + a.x);
        return enc(a.x + b.x);
    endfunction

    function automatic logic [254:0] rand255();
        logic [254:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[222:0], 32'($urandom())};
        return r;
    endfunction

    // Expected op count straight from the schedule rules.
    function automatic int exp_ops(input logic [254:0] k);
        int m;
        int pc;
        m  = -1;
        pc = 0;
        for (int i = 0; i < 255; i++) if (k[i]) begin m = i; pc++; end
`ifdef SCALAR_CONST_TIME_EN
        return 512;
`else
        if (m < 0) return 2;
        return 2 + m + pc - 1;
`endif
    endfunction

    // PointAdd stand-in: random latency, protocol and operand checking.
    int    viol = 0;
    int    op_cnt = 0;
    int    op_log [0:8191];
    logic  st_busy = 1'b0;
    int    st_lat = 0;
    logic [1:0] st_mode = '0;
    pt_t   st_s1 = '0, st_s2 = '0;

    always @(posedge clk) begin
        pa_fin <= 1'b0;
        if (rst) begin
            st_busy <= 1'b0;
        end else if (pa_start) begin
            if (st_busy || !op_ok(pa_init, pa_dbl, s1_cur, s2_cur)) viol <= viol + 1;
            st_busy <= 1'b1;
            st_lat  <= int'($urandom_range(1, 4));
            st_mode <= {pa_init, pa_dbl};
            st_s1   <= s1_cur;
            st_s2   <= s2_cur;
            pa_res  <= pa_eval(pa_init, pa_dbl, s1_cur, s2_cur);
            op_log[op_cnt % 8192] <= pa_init ? 0 : (pa_dbl ? 1 : 2);
            op_cnt  <= op_cnt + 1;
        end else if (st_busy) begin
            if (st_s1 != s1_cur || st_s2 != s2_cur || st_mode != {pa_init, pa_dbl})
                viol <= viol + 1;
            if (st_lat == 1) begin
                pa_fin  <= 1'b1;
                st_busy <= 1'b0;
            end else begin
                st_lat <= st_lat - 1;
            end
        end
    end

    // Issue one request and wait for o_done; optional noise pulses i_start mid-run.
    task automatic do_run(input logic [254:0] k, input logic [254:0] bx, input logic [254:0] by,
                          input bit noise, output bit to, output bit busy1,
                          output int ops0, output int viol0);
        int cyc;
        ops0  = op_cnt;
        viol0 = viol;
        @(posedge clk); #1;
        start = 1'b1; scalar = k; x = bx; y = by;
        @(posedge clk); #1;
        start = 1'b0;
        busy1 = busy;
        cyc = 0;
        while (cyc < LIM) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            start = noise && (cyc % 37 == 5);
            if (start) begin scalar = rand255(); x = rand255(); y = rand255(); end
        end
        start = 1'b0;
        to = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, pa_start, pa_dbl, pa_init} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, pa_start, pa_dbl, pa_init});
        end
        n_tests++;
        if (res_now !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", res_now.x); end
        n_tests++;
        if ({s1_cur, s2_cur} !== '0) begin n_fail++; $display("FAIL reset_operands: got nonzero want 0"); end
        rst = 1'b0;
    endtask

    task automatic test_k_small(input logic [254:0] k, input string nm);
        bit to, b1;
        int o0, v0;
        logic [254:0] bx, by;
        bx = rand255(); by = rand255();
        do_run(k, bx, by, 1'b0, to, b1, o0, v0);
        n_tests++;
        if (to || res_now !== enc(k * base_val(bx, by))) begin
            n_fail++; $display("FAIL %s_result: got %h want %h (timeout %0d)", nm, ox, k * base_val(bx, by), to);
        end
        n_tests++;
        if (op_cnt - o0 !== exp_ops(k)) begin
            n_fail++; $display("FAIL %s_ops: got %0d want %0d", nm, op_cnt - o0, exp_ops(k));
        end
        n_tests++;
        if (viol != v0 || b1 !== 1'b1) begin
            n_fail++; $display("FAIL %s_protocol: violations %0d busy_after_start %b want 0 1", nm, viol - v0, b1);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL %s_idle: got %b want 00", nm, {busy, done}); end
    endtask

    task automatic test_k5_sequence();
        bit to, b1;
        int o0, v0, bad;
        int exp_q[$];
        logic [254:0] k;
        k = 255'd5;
        exp_q = {0, 0};
`ifdef SCALAR_CONST_TIME_EN
        for (int i = 0; i < 255; i++) begin exp_q.push_back(1); exp_q.push_back(2); end
`else
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
`endif
        do_run(k, rand255(), rand255(), 1'b0, to, b1, o0, v0);
        bad = (op_cnt - o0 != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size(); i++) if (op_log[(o0 + i) % 8192] != exp_q[i]) bad++;
        n_tests++;
        if (to || bad != 0) begin
            n_fail++; $display("FAIL k5_sequence: got %0d ops %0d wrong want %0d ops 0 wrong", op_cnt - o0, bad, exp_q.size());
        end
        n_tests++;
        if (viol != v0) begin n_fail++; $display("FAIL k5_overlap: got %0d violations want 0", viol - v0); end
    endtask

    task automatic test_start_ignored();
        bit to, b1;
        int o0, v0;
        logic [254:0] k, bx, by;
        k = '0; k[254] = 1'b1; k[0] = 1'b1;
        bx = rand255(); by = rand255();
        do_run(k, bx, by, 1'b1, to, b1, o0, v0);
        n_tests++;
        if (to || res_now !== enc(k * base_val(bx, by))) begin
            n_fail++; $display("FAIL busy_start_result: got %h want %h", ox, k * base_val(bx, by));
        end
        n_tests++;
        if (op_cnt - o0 !== exp_ops(k) || viol != v0) begin
            n_fail++; $display("FAIL busy_start_ops: got %0d viol %0d want %0d viol 0", op_cnt - o0, viol - v0, exp_ops(k));
        end
    endtask

    task automatic test_done_start();
        bit to, b1;
        int o0, v0;
        logic [254:0] k, bx, by;
        k = 255'($urandom_range(1, 255));
        bx = rand255(); by = rand255();
        do_run(k, bx, by, 1'b0, to, b1, o0, v0);
        start = 1'b1; scalar = rand255(); x = rand255(); y = rand255();
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (to || busy !== 1'b0 || op_cnt != o0 + exp_ops(k)) begin
            n_fail++; $display("FAIL done_start: busy %b ops %0d want busy 0 ops %0d", busy, op_cnt - o0, exp_ops(k));
        end
        n_tests++;
        if (res_now !== enc(k * base_val(bx, by))) begin
            n_fail++; $display("FAIL done_start_hold: got %h want %h", ox, k * base_val(bx, by));
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dones;
        logic [254:0] k;
        k = rand255(); k[254] = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; scalar = k; x = rand255(); y = rand255();
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < LIM && !(pa_dbl && st_busy)) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (!(pa_dbl && st_busy)) begin n_fail++; $display("FAIL reset_mid_reach: got no doubling in flight want one"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({busy, done, pa_start, pa_dbl, pa_init} !== 5'b0 || res_now !== '0 || {s1_cur, s2_cur} !== '0) begin
            n_fail++; $display("FAIL reset_mid_clear: ctrl %b result %h want 00000 0", {busy, done, pa_start, pa_dbl, pa_init}, ox);
        end
        dones = 0;
        repeat (6) begin @(posedge clk); #1; if (done || busy) dones++; end
        n_tests++;
        if (dones != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", dones); end
        test_k_small(255'd3, "k3_after_reset");
    endtask

    initial begin
        test_reset();
        test_k_small(255'd0, "k0");
        test_k_small(255'd1, "k1");
        test_k_small(255'd2, "k2");
        test_k5_sequence();
        test_start_ignored();
        test_reset_mid();
        test_done_start();
        for (int i = 0; i < 4; i++) test_k_small(rand255(), "random");
        test_k_small({255{1'b1}}, "all_ones");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
